// File: rtl/uart_tx_ext.sv
// uart_tx_ext: UART transmitter with configurable frame format, runtime baud
// divisor and an input FIFO behind a valid/ready handshake. Words are sent
// LSB first, back-to-back while the FIFO holds data.
//
// Ports:
//   clk        - single clock
//   rst        - synchronous active-high reset
//   baud_div   - clock cycles per bit, sampled at each frame start (0/1 -> 2)
//   tx_data    - word to send
//   tx_valid   - tx_data is valid; pushed when tx_valid && tx_ready
//   tx_ready   - FIFO not full
//   tx_busy    - frame in progress or FIFO not empty
//   fifo_level - number of stored words (0..FIFO_DEPTH)
//   txd        - registered serial output, idle high
module uart_tx_ext #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          txd
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t state, state_n;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 full, empty, push, pop;

    // Frame datapath
    logic [DATA_BITS-1:0] shift;
    logic [DIV_W-1:0]     div_lat, timer, div_clamp;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 par_bit;
    logic                 bit_end, last_data, last_stop;
    logic [DATA_BITS-1:0] word;

    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = tx_valid && tx_ready;
    assign tx_ready   = !full;
    assign fifo_level = count;
    assign tx_busy    = (state != IDLE) || !empty;

    assign word      = mem[rd_ptr];
    assign div_clamp = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
    assign bit_end   = (timer == '0);
    assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

    // FIFO write port (storage needs no reset)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and pop decision; the final stop bit pops directly into
    // START so consecutive frames have no idle gap.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end && last_data) state_n = (PARITY != 0) ? PAR : STOP;
            end
            PAR: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                if (bit_end && last_stop) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // txd is registered: each branch drives the level of the bit that
    // begins at this edge, so it lines up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd      <= 1'b1;
            shift    <= '0;
            div_lat  <= DIV_W'(2);
            timer    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
        end else if (pop) begin
            shift    <= word;
            div_lat  <= div_clamp;
            timer    <= div_clamp - DIV_W'(1);
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= (PARITY == 1) ? ~(^word) : (^word);
            txd      <= 1'b0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                timer <= div_lat - DIV_W'(1);
                unique case (state)
                    START: txd <= shift[0];
                    DATA: begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_data) begin
                            txd <= (PARITY != 0) ? par_bit : 1'b1;
                        end else begin
                            txd <= shift[1];
                        end
                    end
                    PAR:  txd <= 1'b1;
                    STOP: begin
                        stop_cnt <= ~stop_cnt;
                        txd      <= 1'b1;
                    end
                    default: txd <= 1'b1;
                endcase
            end else begin
                timer <= timer - DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ext.sv
// tb_uart_tx_ext: directed self-checking bench for uart_tx_ext.
// u0 is the default 8N1 build, u1 is 7E2 and u2 is 7O2. Expected line
// levels are hand-built frame vectors (bit 0 = start bit, sent first).
module tb_uart_tx_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [7:0]  tx_data;
    logic        v0, v1, v2;
    logic        rdy0, rdy1, rdy2;
    logic        busy0, busy1, busy2;
    logic        txd0, txd1, txd2;
    logic [2:0]  lvl0, lvl1, lvl2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_ext #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) u0 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .tx_data(tx_data), .tx_valid(v0),
        .tx_ready(rdy0), .tx_busy(busy0), .fifo_level(lvl0), .txd(txd0));

    uart_tx_ext #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(16)) u1 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .tx_data(tx_data[6:0]), .tx_valid(v1),
        .tx_ready(rdy1), .tx_busy(busy1), .fifo_level(lvl1), .txd(txd1));

    uart_tx_ext #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(16)) u2 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .tx_data(tx_data[6:0]), .tx_valid(v2),
        .tx_ready(rdy2), .tx_busy(busy2), .fifo_level(lvl2), .txd(txd2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic txd_of(input int sel);
        return (sel == 0) ? txd0 : (sel == 1) ? txd1 : txd2;
    endfunction

    function automatic logic rdy_of(input int sel);
        return (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 0) v0 = v;
        else if (sel == 1) v1 = v;
        else v2 = v;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int sel, input logic [7:0] w);
        logic r;
        int   tries;
        tx_data = w;
        set_valid(sel, 1'b1);
        tries = 0;
        do begin
            r = rdy_of(sel);
            @(posedge clk);
            @(negedge clk);
            tries++;
        end while (!r && tries < 200);
        if (!r) check("push_timeout", 32'd1, 32'd0);
        set_valid(sel, 1'b0);
    endtask

    // Samples txd once per cycle for nbits bits of div cycles each.
    task automatic check_bits(input int sel, input logic [11:0] bits, input int nbits,
                              input int div, input string tag);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                check(tag, {31'b0, txd_of(sel)}, {31'b0, bits[b]});
            end
        end
    endtask

    logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int low;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        baud_div = 16'd4; tx_data = '0;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd",   {31'b0, txd0},  32'd1);
        check("rst_ready", {31'b0, rdy0},  32'd1);
        check("rst_busy",  {31'b0, busy0}, 32'd0);
        check("rst_level", {29'b0, lvl0},  32'd0);
        rst = 1'b0;
        low = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd0 !== 1'b1) low++;
        end
        check("idle_txd_low", low, 0);

        // 8N1, div 4, 0x55
        baud_div = 16'd4;
        fork
            push(0, 8'h55);
            begin
                @(negedge clk);
                check("pre_start_txd", {31'b0, txd0},  32'd1);
                check("busy_rise",     {31'b0, busy0}, 32'd1);
                check_bits(0, 12'h2AA, 10, 4, "f55_div4");
            end
        join
        @(negedge clk);
        check("busy_fall_8n1", {31'b0, busy0}, 32'd0);

        // 7E2 then 7O2, div 3, 0x41
        baud_div = 16'd3;
        fork
            push(1, 8'h41);
            begin @(negedge clk); check_bits(1, 12'h682, 11, 3, "f41_7e2"); end
        join
        @(negedge clk);
        check("busy_fall_7e2", {31'b0, busy1}, 32'd0);
        fork
            push(2, 8'h41);
            begin @(negedge clk); check_bits(2, 12'h782, 11, 3, "f41_7o2"); end
        join
        @(negedge clk);
        check("busy_fall_7o2", {31'b0, busy2}, 32'd0);

        // baud_div 0 and 1 both clamp to 2-cycle bits
        baud_div = 16'd0;
        fork
            push(0, 8'h55);
            begin @(negedge clk); check_bits(0, 12'h2AA, 10, 2, "div0"); end
        join
        @(negedge clk);
        baud_div = 16'd1;
        fork
            push(0, 8'h55);
            begin @(negedge clk); check_bits(0, 12'h2AA, 10, 2, "div1"); end
        join
        @(negedge clk);

        // Burst of 6 words at div 2: backpressure and contiguous frames
        baud_div = 16'd2;
        fork
            begin
                for (int i = 0; i < 6; i++) push(0, words[i]);
            end
            begin
                @(negedge clk);
                check("burst_lvl_first", {29'b0, lvl0}, 32'd1);
                for (int i = 0; i < 6; i++)
                    check_bits(0, {2'b00, 1'b1, words[i], 1'b0}, 10, 2, "burst");
            end
            begin
                repeat (5) @(negedge clk);
                check("full_level",  {29'b0, lvl0}, 32'd4);
                check("full_ready",  {31'b0, rdy0}, 32'd0);
                repeat (17) @(negedge clk);
                check("pop_level",   {29'b0, lvl0}, 32'd3);
                check("pop_ready",   {31'b0, rdy0}, 32'd1);
                @(negedge clk);
                check("refill_level", {29'b0, lvl0}, 32'd4);
                check("refill_ready", {31'b0, rdy0}, 32'd0);
            end
        join
        @(negedge clk);
        check("burst_busy_end", {31'b0, busy0}, 32'd0);
        check("burst_lvl_end",  {29'b0, lvl0},  32'd0);

        // baud_div 4 -> 8 in mid-frame: first frame stays at 4
        baud_div = 16'd4;
        fork
            begin push(0, 8'h0F); push(0, 8'hF0); end
            begin
                @(negedge clk);
                check_bits(0, 12'h21E, 10, 4, "divchg_a");
                check_bits(0, 12'h3E0, 10, 8, "divchg_b");
            end
            begin repeat (12) @(negedge clk); baud_div = 16'd8; end
        join
        @(negedge clk);
        check("divchg_busy_end", {31'b0, busy0}, 32'd0);

        // Reset during data bits with two words queued
        baud_div = 16'd4;
        fork
            begin push(0, 8'h3C); push(0, 8'hA5); push(0, 8'h5A); end
            begin
                repeat (8) @(negedge clk);
                check("mid_data_txd",   {31'b0, txd0}, 32'd0);
                check("mid_data_level", {29'b0, lvl0}, 32'd2);
                rst = 1'b1;
                @(negedge clk);
                check("midrst_txd",   {31'b0, txd0},  32'd1);
                check("midrst_level", {29'b0, lvl0},  32'd0);
                check("midrst_busy",  {31'b0, busy0}, 32'd0);
                check("midrst_ready", {31'b0, rdy0},  32'd1);
                rst = 1'b0;
            end
        join
        low = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd0 !== 1'b1 || busy0 !== 1'b0) low++;
        end
        check("after_rst_quiet", low, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
